// File: rtl/uart_frame_tx.sv
// uart_frame_tx: Modbus-RTU frame transmitter with optional CRC16 and 3.5-char post-frame gap
module uart_frame_tx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int MAX_LEN   = 16,
  parameter int LEN_W     = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       wr_en,
  input  logic [$clog2(MAX_LEN)-1:0] wr_addr,
  input  logic [7:0]                 wr_data,
  input  logic                       start,
  input  logic [LEN_W-1:0]           frame_len,
  input  logic                       crc_append,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_done,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       len_err,
  output logic [15:0]                crc_out
);
  localparam int AW = $clog2(MAX_LEN);
  localparam int GAP_CYCLES = (CLK_FREQ / BAUD_RATE) * 35;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, GAP} state_t;
  state_t state, nxt;
  logic [7:0] mem [MAX_LEN];
  logic [LEN_W-1:0] len, idx;
  logic [1:0] sel;
  logic crc_en;
  logic [15:0] crc;
  logic [7:0] sh;
  logic [3:0] bcnt;
  logic [GW-1:0] gcnt;
  logic len_ok, accept, more, gap_end, fb;
  assign len_ok  = frame_len != '0 && frame_len <= LEN_W'(MAX_LEN);
  assign accept  = state == IDLE && start && !frame_done && len_ok;
  assign more    = (sel == 2'd0 && (idx != len - 1'b1 || crc_en)) || sel == 2'd1;
  assign gap_end = state == GAP && gcnt == GW'(GAP_CYCLES - 2);
  assign fb      = crc[0] ^ sh[0];
  // payload buffer, writable at any time and never cleared
  always_ff @(posedge clk_in)
    if (wr_en) mem[wr_addr] <= wr_data;
  // state register
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) state <= IDLE;
    else state <= nxt;
  // next-state logic; sel tracks payload / crc-low / crc-high so one LOAD-SEND-WAIT loop serves all bytes
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = accept ? LOAD : IDLE;
      LOAD:    nxt = SEND;
      SEND:    nxt = WAIT;
      WAIT:    nxt = !tx_done ? WAIT : more ? LOAD : GAP;
      GAP:     nxt = gap_end ? IDLE : GAP;
      default: nxt = IDLE;
    endcase
  end
  // state-decoded outputs
  always_comb begin
    tx_start = state == SEND;
    busy     = state != IDLE;
  end
  // datapath: byte selection, bit-serial CRC overlapping WAIT, gap counter and result capture
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tx_data    <= '0;
      crc        <= 16'hFFFF;
      crc_out    <= 16'hFFFF;
      idx        <= '0;
      len        <= '0;
      sel        <= '0;
      crc_en     <= 1'b0;
      sh         <= '0;
      bcnt       <= '0;
      gcnt       <= '0;
      len_err    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      len_err    <= state == IDLE && start && !frame_done && !len_ok;
      frame_done <= gap_end;
      gcnt       <= state == GAP ? gcnt + 1'b1 : '0;
      if (gap_end) crc_out <= crc;
      if (state == LOAD)
        tx_data <= sel == 2'd0 ? mem[idx[AW-1:0]] : sel == 2'd1 ? crc[7:0] : crc[15:8];
      if (state == SEND && sel == 2'd0) begin
        sh   <= tx_data;
        bcnt <= 4'd8;
      end else if (bcnt != '0) begin
        crc  <= {1'b0, crc[15:1]} ^ (fb ? 16'hA001 : 16'h0000);
        sh   <= sh >> 1;
        bcnt <= bcnt - 1'b1;
      end
      if (state == WAIT && tx_done) begin
        if (sel == 2'd0 && idx != len - 1'b1) idx <= idx + 1'b1;
        else if (more) sel <= sel + 1'b1;
      end
      if (accept) begin
        len    <= frame_len;
        crc_en <= crc_append;
        crc    <= 16'hFFFF;
        idx    <= '0;
        sel    <= '0;
      end
    end
  end
endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: directed tests of the Modbus frame transmitter against a byte-UART responder model
module tb_uart_frame_tx;
  localparam int BYTE_CYC = 24;
  localparam int GAP_S = 350;
  localparam int GAP_B = 15190;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic start = 1'b0, start_b = 1'b0;
  logic [7:0] frame_len = '0;
  logic crc_append = 1'b0;
  logic tx_start, tx_done, busy, frame_done, len_err;
  logic [7:0] tx_data;
  logic [15:0] crc_out;
  logic tx_start_b, tx_done_b, busy_b, frame_done_b, len_err_b;
  logic [7:0] tx_data_b;
  logic [15:0] crc_out_b;
  logic [7:0] cap[$];
  logic [7:0] cap_b[$];
  logic [7:0] pay[16];
  int rc = 0, rc_b = 0, cyc = 0, n_lerr = 0;
  int passed = 0, total = 0;
  int t_done, t_fd;
  logic ok;
  always #5 clk_in = ~clk_in;
  uart_frame_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .frame_len(frame_len), .crc_append(crc_append), .tx_start(tx_start),
    .tx_data(tx_data), .tx_done(tx_done), .busy(busy), .frame_done(frame_done),
    .len_err(len_err), .crc_out(crc_out));
  uart_frame_tx dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start_b), .frame_len(frame_len), .crc_append(crc_append), .tx_start(tx_start_b),
    .tx_data(tx_data_b), .tx_done(tx_done_b), .busy(busy_b), .frame_done(frame_done_b),
    .len_err(len_err_b), .crc_out(crc_out_b));
  always @(posedge clk_in) cyc <= cyc + 1;
  always @(posedge clk_in) if (len_err) n_lerr <= n_lerr + 1;
  // byte-UART model for the small-gap instance: captures each byte, acks BYTE_CYC cycles later
  always @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      rc <= 0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= rc == 1;
      if (tx_start) begin
        rc <= BYTE_CYC;
        cap.push_back(tx_data);
      end else if (rc != 0) rc <= rc - 1;
    end
  // same model for the default-parameter instance
  always @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      rc_b <= 0;
      tx_done_b <= 1'b0;
    end else begin
      tx_done_b <= rc_b == 1;
      if (tx_start_b) begin
        rc_b <= BYTE_CYC;
        cap_b.push_back(tx_data_b);
      end else if (rc_b != 0) rc_b <= rc_b - 1;
    end
  function automatic logic [15:0] crc16(input logic [7:0] d[16], input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {8'h00, d[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction
  task automatic wr(input int a, input logic [7:0] d);
    @(negedge clk_in);
    wr_en = 1'b1;
    wr_addr = 4'(a);
    wr_data = d;
    @(negedge clk_in);
    wr_en = 1'b0;
  endtask
  task automatic load_pay(input int n);
    for (int i = 0; i < n; i++) wr(i, pay[i]);
  endtask
  task automatic launch(input int n, input logic ce);
    cap.delete();
    @(negedge clk_in);
    frame_len = 8'(n);
    crc_append = ce;
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
  endtask
  task automatic wait_fd(input int budget);
    ok = 1'b0;
    t_done = -1;
    t_fd = -1;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk_in);
      if (tx_done) t_done = cyc;
      if (frame_done) begin
        t_fd = cyc;
        ok = 1'b1;
      end
    end
    total++;
    if (!ok) $display("FAIL frame_done timeout: got none within %0d cycles, required a pulse", budget);
    else passed++;
  endtask
  task automatic test_reset;
    @(negedge clk_in);
    total++; if (tx_start !== 1'b0) $display("FAIL reset tx_start: got %b expected 0", tx_start); else passed++;
    total++; if (tx_data !== 8'h00) $display("FAIL reset tx_data: got %h expected 00", tx_data); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", busy); else passed++;
    total++; if (frame_done !== 1'b0 || len_err !== 1'b0) $display("FAIL reset pulses: got %b%b expected 00", frame_done, len_err); else passed++;
    total++; if (crc_out !== 16'hFFFF) $display("FAIL reset crc_out: got %h expected ffff", crc_out); else passed++;
    total++; if (crc_out_b !== 16'hFFFF || busy_b !== 1'b0) $display("FAIL reset big: got %h/%b expected ffff/0", crc_out_b, busy_b); else passed++;
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask
  task automatic test_basic;
    logic [7:0] exp[8];
    exp = '{8'h01, 8'h03, 8'h00, 8'h01, 8'h00, 8'h01, 8'hD5, 8'hCA};
    pay = '{8'h01, 8'h03, 8'h00, 8'h01, 8'h00, 8'h01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    load_pay(6);
    launch(6, 1'b1);
    total++; if (tx_start !== 1'b0 || busy !== 1'b1) $display("FAIL basic load cycle: got start=%b busy=%b expected 0 1", tx_start, busy); else passed++;
    @(negedge clk_in);
    total++; if (tx_start !== 1'b1 || tx_data !== 8'h01) $display("FAIL basic first byte latency: got start=%b data=%h expected 1 01", tx_start, tx_data); else passed++;
    wait_fd(2000);
    total++; if (cap.size() != 8) $display("FAIL basic byte count: got %0d expected 8", cap.size()); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i >= cap.size() || cap[i] !== exp[i]) $display("FAIL basic byte %0d: got %h expected %h", i, (i < cap.size()) ? cap[i] : 8'hxx, exp[i]);
      else passed++;
    end
    total++; if (crc_out !== 16'hCAD5) $display("FAIL basic crc_out: got %h expected cad5", crc_out); else passed++;
    total++; if (t_fd - t_done != GAP_S) $display("FAIL basic gap: got %0d expected %0d", t_fd - t_done, GAP_S); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL basic busy at frame_done: got %b expected 0", busy); else passed++;
  endtask
  task automatic test_gap_default;
    int nd, t8, tf;
    nd = 0; t8 = -1; tf = -1;
    cap_b.delete();
    @(negedge clk_in);
    frame_len = 8'd6;
    crc_append = 1'b1;
    start_b = 1'b1;
    @(negedge clk_in);
    start_b = 1'b0;
    for (int i = 0; i < 20000 && tf < 0; i++) begin
      @(negedge clk_in);
      if (tx_done_b) begin
        nd++;
        if (nd == 8) t8 = cyc;
      end
      if (frame_done_b) tf = cyc;
    end
    total++; if (tf < 0 || t8 < 0 || tf - t8 != GAP_B) $display("FAIL default gap: got %0d expected %0d", tf - t8, GAP_B); else passed++;
    total++; if (crc_out_b !== 16'hCAD5) $display("FAIL default crc_out: got %h expected cad5", crc_out_b); else passed++;
    total++; if (cap_b.size() != 8 || cap_b[6] !== 8'hD5 || cap_b[7] !== 8'hCA) $display("FAIL default crc bytes: got n=%0d expected 8 ending d5 ca", cap_b.size()); else passed++;
  endtask
  task automatic test_no_crc;
    logic [7:0] exp[8];
    exp = '{8'h01, 8'h03, 8'h00, 8'h01, 8'h00, 8'h01, 8'hD5, 8'hCA};
    pay = '{8'h01, 8'h03, 8'h00, 8'h01, 8'h00, 8'h01, 8'hD5, 8'hCA, 0, 0, 0, 0, 0, 0, 0, 0};
    load_pay(8);
    launch(8, 1'b0);
    wait_fd(2000);
    total++; if (cap.size() != 8) $display("FAIL nocrc byte count: got %0d expected 8", cap.size()); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i >= cap.size() || cap[i] !== exp[i]) $display("FAIL nocrc byte %0d: got %h expected %h", i, (i < cap.size()) ? cap[i] : 8'hxx, exp[i]);
      else passed++;
    end
    total++; if (crc_out !== 16'h0000) $display("FAIL nocrc residue: got %h expected 0000", crc_out); else passed++;
  endtask
  task automatic test_len_limits;
    int base, bad;
    logic [15:0] m;
    base = n_lerr;
    cap.delete();
    launch(0, 1'b1);
    total++; if (len_err !== 1'b1 || busy !== 1'b0) $display("FAIL len0 pulse: got len_err=%b busy=%b expected 1 0", len_err, busy); else passed++;
    @(negedge clk_in);
    total++; if (len_err !== 1'b0) $display("FAIL len0 pulse width: got %b expected 0", len_err); else passed++;
    launch(17, 1'b1);
    total++; if (len_err !== 1'b1 || busy !== 1'b0) $display("FAIL len17 pulse: got len_err=%b busy=%b expected 1 0", len_err, busy); else passed++;
    repeat (10) @(negedge clk_in);
    total++; if (n_lerr - base != 2 || cap.size() != 0) $display("FAIL len rejects: got %0d pulses %0d bytes expected 2 and 0", n_lerr - base, cap.size()); else passed++;
    for (int i = 0; i < 16; i++) pay[i] = 8'(i * 37 + 5);
    load_pay(16);
    m = crc16(pay, 16);
    launch(16, 1'b1);
    wait_fd(3000);
    total++; if (cap.size() != 18) $display("FAIL maxlen byte count: got %0d expected 18", cap.size()); else passed++;
    bad = 0;
    for (int i = 0; i < 16 && i < cap.size(); i++) if (cap[i] !== pay[i]) bad++;
    total++; if (bad != 0) $display("FAIL maxlen payload: got %0d wrong bytes expected 0", bad); else passed++;
    total++; if (cap.size() != 18 || cap[16] !== m[7:0] || cap[17] !== m[15:8]) $display("FAIL maxlen crc bytes: got n=%0d expected crc %h", cap.size(), m); else passed++;
    total++; if (crc_out !== m) $display("FAIL maxlen crc_out: got %h expected %h", crc_out, m); else passed++;
  endtask
  task automatic test_ignore_start;
    int base;
    pay = '{8'h01, 8'h03, 8'h00, 8'h01, 8'h00, 8'h01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    load_pay(6);
    base = n_lerr;
    launch(6, 1'b1);
    for (int i = 0; i < 500 && cap.size() < 3; i++) @(negedge clk_in);
    frame_len = 8'd3;
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    total++; if (busy !== 1'b1 || len_err !== 1'b0) $display("FAIL ignore mid-frame: got busy=%b len_err=%b expected 1 0", busy, len_err); else passed++;
    frame_len = 8'd6;
    wait_fd(2000);
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    repeat (60) @(negedge clk_in);
    total++; if (cap.size() != 8 || busy !== 1'b0) $display("FAIL ignore frame count: got %0d bytes busy=%b expected 8 0", cap.size(), busy); else passed++;
    total++; if (n_lerr != base || crc_out !== 16'hCAD5) $display("FAIL ignore side effects: got %0d len_err crc %h expected 0 cad5", n_lerr - base, crc_out); else passed++;
  endtask
  task automatic test_reset_mid;
    logic [7:0] exp[8];
    exp = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h05, 8'h18, 8'h09};
    pay = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h05, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    load_pay(6);
    launch(6, 1'b1);
    for (int i = 0; i < 500 && cap.size() < 4; i++) @(negedge clk_in);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    total++; if (tx_start !== 1'b0 || busy !== 1'b0) $display("FAIL midreset ctl: got start=%b busy=%b expected 0 0", tx_start, busy); else passed++;
    total++; if (tx_data !== 8'h00 || crc_out !== 16'hFFFF) $display("FAIL midreset data: got %h %h expected 00 ffff", tx_data, crc_out); else passed++;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (40) @(negedge clk_in);
    total++; if (cap.size() != 4 || busy !== 1'b0) $display("FAIL midreset halt: got %0d bytes busy=%b expected 4 0", cap.size(), busy); else passed++;
    launch(6, 1'b1);
    wait_fd(2000);
    total++; if (cap.size() != 8) $display("FAIL resend byte count: got %0d expected 8", cap.size()); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i >= cap.size() || cap[i] !== exp[i]) $display("FAIL resend byte %0d: got %h expected %h", i, (i < cap.size()) ? cap[i] : 8'hxx, exp[i]);
      else passed++;
    end
    total++; if (crc_out !== 16'h0918) $display("FAIL resend crc_out: got %h expected 0918", crc_out); else passed++;
  endtask
  initial begin
    test_reset;
    test_basic;
    test_gap_default;
    test_no_crc;
    test_len_limits;
    test_ignore_start;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
